// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one sequential 4x4 signed Booth multiplier among NREQ
// requesters, sequencing start/operands and answering with an error if ready never returns.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [7:0]        rsp_p,
    output logic              rsp_err,
    output logic              busy,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    output logic              mul_start,
    input  logic [7:0]        mul_p,
    input  logic              mul_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // IDLE arbitrate | ISSUE start pulse | WAIT await ready or timeout | RESP response pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] last_grant_next;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] id_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]      mul_a_next;
    logic [3:0]      mul_b_next;
    logic            mul_start_next;
    logic            rsp_valid_next;
    logic [ID_W-1:0] rsp_id_next;
    logic [7:0]      rsp_p_next;
    logic            rsp_err_next;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [3:0]      sel_a;
    logic [3:0]      sel_b;
    logic            transfer;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a = req_a[4*i +: 4];
                sel_b = req_b[4*i +: 4];
            end
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        id_next         = id_q;
        cnt_next        = cnt;
        mul_a_next      = mul_a;
        mul_b_next      = mul_b;
        mul_start_next  = 1'b0;
        rsp_valid_next  = 1'b0;
        rsp_id_next     = rsp_id;
        rsp_p_next      = rsp_p;
        rsp_err_next    = rsp_err;
        case (state)
            IDLE: begin
                if (transfer) begin
                    mul_a_next      = sel_a;
                    mul_b_next      = sel_b;
                    id_next         = grant_idx;
                    last_grant_next = grant_idx;
                    mul_start_next  = 1'b1;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    rsp_p_next     = mul_p;
                    rsp_err_next   = 1'b0;
                    rsp_id_next    = id_q;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_p_next     = '0;
                        rsp_err_next   = 1'b1;
                        rsp_id_next    = id_q;
                        rsp_valid_next = 1'b1;
                        state_next     = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(NREQ - 1);
            id_q       <= '0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_p      <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            id_q       <= id_next;
            cnt        <= cnt_next;
            mul_a      <= mul_a_next;
            mul_b      <= mul_b_next;
            mul_start  <= mul_start_next;
            rsp_valid  <= rsp_valid_next;
            rsp_id     <= rsp_id_next;
            rsp_p      <= rsp_p_next;
            rsp_err    <= rsp_err_next;
        end
    end

endmodule
